// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM with debounced inc/dec buttons, direct duty write, edge/center alignment.
// Outputs registered one cycle after counter evaluation; no backpressure, duty changes apply at period boundaries.
module pwm_multi_ch #(
  parameter int CHANNELS   = 4,
  parameter int CW         = 8,
  parameter int PERIOD     = 10,
  parameter int DUTY_INIT  = 5,
  parameter int STEP       = 1,
  parameter int DEB_DIV    = 2,
  parameter int DEB_STABLE = 3,
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CHANNELS-1:0]    inc_btn,
  input  logic [CHANNELS-1:0]    dec_btn,
  input  logic                   mode,
  input  logic                   duty_wr_en,
  input  logic [CHW-1:0]         duty_wr_ch,
  input  logic [CW-1:0]          duty_wr_val,
  output logic [CHANNELS-1:0]    pwm_out,
  output logic [CHANNELS*CW-1:0] duty_out,
  output logic                   period_start
);

  localparam int NB = 2 * CHANNELS;
  localparam int PW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam int SW = $clog2(DEB_STABLE + 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(DEB_DIV - 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(DEB_STABLE);
  localparam logic [CW-1:0] PER      = CW'(PERIOD);
  localparam logic [CW-1:0] PER_M1   = CW'(PERIOD - 1);
  localparam logic [CW-1:0] INIT     = CW'(DUTY_INIT);
  localparam logic [CW:0]   STEP_W   = (CW + 1)'(STEP);

  logic [PW-1:0]       presc_q, presc_d;
  logic                tick;
  logic [NB-1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NB-1:0]       deb_q, deb_d, press_q, press_d;
  logic [SW-1:0]       stab_q [NB];
  logic [SW-1:0]       stab_d [NB];
  logic [CW-1:0]       shadow_q [CHANNELS];
  logic [CW-1:0]       shadow_d [CHANNELS];
  logic [CW-1:0]       active_q [CHANNELS];
  logic [CW-1:0]       active_d [CHANNELS];
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                up_q, up_d, mode_q, mode_d;
  logic                boundary;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                ps_q, ps_d;

  // Button path: buttons packed as {dec, inc}, so index c is inc and CHANNELS+c is dec.
  always_comb begin
    tick    = (presc_q == PRE_MAX);
    presc_d = tick ? '0 : presc_q + 1'b1;
    sync1_d = {dec_btn, inc_btn};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int b = 0; b < NB; b++) begin
      stab_d[b] = stab_q[b];
      if (tick) begin
        if (sync2_q[b] != deb_q[b]) begin
          if (stab_q[b] == STAB_MAX - 1'b1) begin
            deb_d[b]  = sync2_q[b];
            stab_d[b] = '0;
          end else begin
            stab_d[b] = stab_q[b] + 1'b1;
          end
        end else begin
          stab_d[b] = '0;
        end
      end
    end
    press_d = deb_d & ~deb_q;
  end

  always_comb begin
    logic [CW:0] sum;
    logic        inc_p, dec_p;
    sum   = '0;
    inc_p = 1'b0;
    dec_p = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      shadow_d[c] = shadow_q[c];
      inc_p       = press_q[c];
      dec_p       = press_q[CHANNELS + c];
      sum         = {1'b0, shadow_q[c]} + STEP_W;
      if (duty_wr_en && (duty_wr_ch == CHW'(c))) begin
        shadow_d[c] = (duty_wr_val > PER) ? PER : duty_wr_val;
      end else if (inc_p && !dec_p) begin
        shadow_d[c] = (sum > {1'b0, PER}) ? PER : sum[CW-1:0];
      end else if (dec_p && !inc_p) begin
        shadow_d[c] = ({1'b0, shadow_q[c]} >= STEP_W) ? shadow_q[c] - STEP_W[CW-1:0] : '0;
      end
    end
  end

  // Center mode holds each endpoint for two cycles: the direction flips instead of the count moving.
  always_comb begin
    boundary = mode_q ? (!up_q && (cnt_q == '0)) : (cnt_q == PER_M1);
    cnt_d    = cnt_q;
    up_d     = up_q;
    mode_d   = mode_q;
    for (int c = 0; c < CHANNELS; c++) begin
      active_d[c] = active_q[c];
      pwm_d[c]    = (cnt_q < active_q[c]);
    end
    ps_d = (cnt_q == '0) && up_q;
    if (boundary) begin
      cnt_d  = '0;
      up_d   = 1'b1;
      mode_d = mode;
      for (int c = 0; c < CHANNELS; c++) begin
        active_d[c] = shadow_q[c];
      end
    end else if (mode_q && up_q && (cnt_q == PER_M1)) begin
      up_d = 1'b0;
    end else if (mode_q && !up_q) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      press_q <= '0;
      for (int b = 0; b < NB; b++) begin
        stab_q[b] <= '0;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        shadow_q[c] <= INIT;
        active_q[c] <= INIT;
      end
      cnt_q  <= '0;
      up_q   <= 1'b1;
      mode_q <= 1'b0;
      pwm_q  <= '0;
      ps_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      press_q <= press_d;
      for (int b = 0; b < NB; b++) begin
        stab_q[b] <= stab_d[b];
      end
      for (int c = 0; c < CHANNELS; c++) begin
        shadow_q[c] <= shadow_d[c];
        active_q[c] <= active_d[c];
      end
      cnt_q  <= cnt_d;
      up_q   <= up_d;
      mode_q <= mode_d;
      pwm_q  <= pwm_d;
      ps_q   <= ps_d;
    end
  end

  always_comb begin
    duty_out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      duty_out[c*CW +: CW] = active_q[c];
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: period-position reference model checked every cycle, plus directed steps.
module tb_pwm_multi_ch;
  localparam int CH   = 4;
  localparam int CW   = 8;
  localparam int P    = 10;
  localparam int INIT = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CH-1:0]    inc_btn = '0;
  logic [CH-1:0]    dec_btn = '0;
  logic             mode = 1'b0;
  logic             duty_wr_en = 1'b0;
  logic [1:0]       duty_wr_ch = '0;
  logic [CW-1:0]    duty_wr_val = '0;
  logic [CH-1:0]    pwm_out;
  logic [CH*CW-1:0] duty_out;
  logic             period_start;

  pwm_multi_ch #(
    .CHANNELS(CH), .CW(CW), .PERIOD(P), .DUTY_INIT(INIT),
    .STEP(1), .DEB_DIV(2), .DEB_STABLE(3)
  ) dut (
    .clk(clk), .rst(rst), .inc_btn(inc_btn), .dec_btn(dec_btn), .mode(mode),
    .duty_wr_en(duty_wr_en), .duty_wr_ch(duty_wr_ch), .duty_wr_val(duty_wr_val),
    .pwm_out(pwm_out), .duty_out(duty_out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the current period plus applied/pending duties.
  int      m_pos = 0;
  bit      m_mode = 1'b0;
  int      m_active [CH] = '{INIT, INIT, INIT, INIT};
  int      m_shadow [CH] = '{INIT, INIT, INIT, INIT};
  bit [CH-1:0] exp_pwm = '0;
  bit      exp_ps = 1'b0;
  bit [CH-1:0] busy = '0;
  int      mlen, mcv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > P) ? P : v;
  endfunction

  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (!busy[c]) begin
        chk($sformatf("pwm%0d", c), 32'(pwm_out[c]), 32'(exp_pwm[c]));
        chk($sformatf("duty%0d", c), 32'(duty_out[c*CW +: CW]), m_active[c]);
      end
    end
    chk("period_start", 32'(period_start), 32'(exp_ps));
    if (rst) begin
      m_pos  = 0;
      m_mode = 1'b0;
      for (int c = 0; c < CH; c++) begin
        m_active[c] = INIT;
        m_shadow[c] = INIT;
      end
      exp_pwm = '0;
      exp_ps  = 1'b0;
    end else begin
      mlen = m_mode ? 2 * P : P;
      mcv  = (m_pos < P) ? m_pos : 2 * P - 1 - m_pos;
      for (int c = 0; c < CH; c++) exp_pwm[c] = (mcv < m_active[c]);
      exp_ps = (m_pos == 0);
      if (m_pos == mlen - 1) begin
        m_pos  = 0;
        m_mode = mode;
        for (int c = 0; c < CH; c++) m_active[c] = m_shadow[c];
      end else begin
        m_pos++;
      end
      if (duty_wr_en) m_shadow[duty_wr_ch] = clamp(int'(duty_wr_val));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int val);
    duty_wr_en  = 1'b1;
    duty_wr_ch  = 2'(ch);
    duty_wr_val = CW'(val);
    cyc(1);
    duty_wr_en  = 1'b0;
  endtask

  // A held press counts once; exact pulse cycle is left open, so the channel is masked until settled.
  task automatic press(input int ch, input bit is_dec);
    busy[ch] = 1'b1;
    if (is_dec) m_shadow[ch] = (m_shadow[ch] > 0) ? m_shadow[ch] - 1 : 0;
    else        m_shadow[ch] = clamp(m_shadow[ch] + 1);
    if (is_dec) dec_btn[ch] = 1'b1; else inc_btn[ch] = 1'b1;
    cyc(20);
    dec_btn[ch] = 1'b0;
    inc_btn[ch] = 1'b0;
    cyc(45);
    busy[ch] = 1'b0;
  endtask

  task automatic measure(output int len, output int hi);
    int n;
    n = 0;
    while (period_start !== 1'b1 && n < 100) begin cyc(1); n++; end
    len = 0;
    hi  = 0;
    do begin
      if (pwm_out[0] === 1'b1) hi++;
      cyc(1);
      len++;
    end while (period_start !== 1'b1 && len < 100);
  endtask

  initial begin
    int len, hi;
    logic [CH*CW-1:0] rst_duty;
    rst_duty = {CH{8'(INIT)}};

    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("first_period_start", 32'(period_start), 1);
    cyc(25);
    measure(len, hi);
    chk("edge_len", len, P);
    chk("edge_hi", hi, INIT);

    press(0, 1'b0);
    chk("press_once_ch0", 32'(duty_out[0 +: CW]), 6);
    measure(len, hi);
    chk("edge_hi_duty6", hi, 6);

    for (int i = 0; i < 14; i++) begin
      inc_btn[1] = ~inc_btn[1];
      cyc(3);
    end
    inc_btn[1] = 1'b0;
    cyc(40);
    chk("bounce_ch1", 32'(duty_out[1*CW +: CW]), INIT);

    wr(2, 10);  cyc(25);
    chk("sat_write10", 32'(duty_out[2*CW +: CW]), 10);
    press(2, 1'b0);
    chk("sat_inc", 32'(duty_out[2*CW +: CW]), 10);
    wr(2, 0);   cyc(25);
    chk("sat_write0", 32'(duty_out[2*CW +: CW]), 0);
    press(2, 1'b1);
    chk("sat_dec", 32'(duty_out[2*CW +: CW]), 0);
    wr(2, 200); cyc(25);
    chk("clamp200", 32'(duty_out[2*CW +: CW]), 10);

    inc_btn[3] = 1'b1;
    dec_btn[3] = 1'b1;
    cyc(20);
    inc_btn[3] = 1'b0;
    dec_btn[3] = 1'b0;
    cyc(45);
    chk("inc_dec_same", 32'(duty_out[3*CW +: CW]), INIT);

    busy[3] = 1'b1;
    inc_btn[3] = 1'b1;
    repeat (20) wr(3, 7);
    inc_btn[3] = 1'b0;
    cyc(45);
    busy[3] = 1'b0;
    chk("write_beats_inc", 32'(duty_out[3*CW +: CW]), 7);

    for (int i = 0; i < 800; i++) begin
      if (i % 200 == 100) mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        duty_wr_en  = 1'b1;
        duty_wr_ch  = 2'($urandom_range(0, CH - 1));
        duty_wr_val = ($urandom_range(0, 1) == 1) ? CW'($urandom_range(0, P)) : CW'($urandom_range(0, 255));
      end
      cyc(1);
      duty_wr_en = 1'b0;
    end

    mode = 1'b0;
    wr(0, 5);
    cyc(45);
    measure(len, hi);
    chk("edge_len_again", len, P);
    cyc(4);
    mode = 1'b1;
    measure(len, hi);
    measure(len, hi);
    chk("center_len", len, 2 * P);
    chk("center_hi", hi, 2 * 5);

    cyc(7);
    wr(1, 9);
    rst = 1'b1;
    cyc(1);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_ps", 32'(period_start), 0);
    chk("rst_duty", duty_out, rst_duty);
    rst = 1'b0;
    cyc(60);
    chk("rst_pending_lost", 32'(duty_out[1*CW +: CW]), INIT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
